// File: rtl/wave_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_meter_pkg
//  Description : Shared types and defaults for the square-wave duty meter.
//                meter_state_t - measurement FSM states
//                SYNC_DEFAULT  - default input synchronizer depth
//                CW_DEFAULT    - default measurement width in cycles
//  Revision    : 1.0 - initial release
// ============================================================================
package wave_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting to see the signal low
        ARMED = 2'd1,   // low seen; next rise starts a measured high
        HIGH  = 2'd2,   // timing a high level
        LOW   = 2'd3    // timing a low level
    } meter_state_t;

    localparam int SYNC_DEFAULT = 2;
    localparam int CW_DEFAULT   = 8;

endpackage : wave_meter_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous level input,
//                followed by a one-cycle-delayed copy used to form single-
//                cycle rise and fall pulses on the synchronized signal.
//  Ports       : clk      in  1  system clock, rising edge
//                rst      in  1  asynchronous active-high reset
//                i_sig    in  1  raw asynchronous input
//                o_sig_s  out 1  synchronized level
//                o_rise   out 1  high for one cycle when o_sig_s goes 0->1
//                o_fall   out 1  high for one cycle when o_sig_s goes 1->0
//  Parameters  : SYNC     synchronizer depth in flops, legal range 2..3
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det
    import wave_meter_pkg::*;
#(
    parameter int SYNC = SYNC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_sig_s,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC-1:0] r_sync;
    logic            r_sig_d;

    // Bit 0 is the metastability-catching flop; the MSB is the clean level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC-2:0], i_sig};
            r_sig_d <= r_sync[SYNC-1];
        end
    end

    assign o_sig_s = r_sync[SYNC-1];
    assign o_rise  =  o_sig_s & ~r_sig_d;
    assign o_fall  = ~o_sig_s &  r_sig_d;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/wave_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module      : wave_duty_meter
//  Description : Measures high time, low time and period (in clock cycles)
//                of a square wave. A report is produced once per complete
//                period, at the rise that ends the low phase, together with
//                a one-cycle valid strobe. Durations saturate at 2^CW-1.
//  Ports       : clock        in  1     system clock, rising edge
//                reset        in  1     asynchronous active-high reset
//                clear        in  1     synchronous re-arm (FSM to IDLE)
//                sig_in       in  1     square wave under measurement
//                high_count   out CW    high cycles of the last full period
//                low_count    out CW    low cycles of the last full period
//                period_count out CW+1  high_count + low_count
//                sat          out 1     a count in the last report saturated
//                valid        out 1     one-cycle strobe for a new report
//  Parameters  : CW           measurement width (saturating)
//                SYNC         input synchronizer depth, 2..3
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_duty_meter
    import wave_meter_pkg::*;
#(
    parameter int CW   = CW_DEFAULT,
    parameter int SYNC = SYNC_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          sig_in,
    output logic [CW-1:0] high_count,
    output logic [CW-1:0] low_count,
    output logic [CW:0]   period_count,
    output logic          sat,
    output logic          valid
);

    localparam logic [CW-1:0] c_max = '1;
    localparam logic [CW-1:0] c_one = CW'(1);

    logic          w_sig_s;
    logic          w_rise;
    logic          w_fall;

    meter_state_t  r_state;
    meter_state_t  w_state_nxt;
    logic          w_latch_hi;
    logic          w_report;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hi_tmp;

    // ------------------------------------------------------------------------
    // Input synchronizer and edge pulses
    // ------------------------------------------------------------------------
    sync_edge_det #(
        .SYNC    (SYNC)
    ) u_sync_edge_det (
        .clk     (clock),
        .rst     (reset),
        .i_sig   (sig_in),
        .o_sig_s (w_sig_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // ------------------------------------------------------------------------
    // Run-length counter. Restarting at 1 on an edge means that on the next
    // edge cycle the count equals the length of the level that just ended.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_rise || w_fall) begin
            r_cnt <= c_one;
        end else if (r_cnt != c_max) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    // ------------------------------------------------------------------------
    // Measurement FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Measurement FSM: next state and control strobes. clear overrides every
    // transition, including the report-producing LOW->HIGH rise.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch_hi  = 1'b0;
        w_report    = 1'b0;

        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // Arming only on a low level guarantees the first
                    // measured high begins at a genuine rising edge.
                    if (!w_sig_s) begin
                        w_state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_state_nxt = LOW;
                        w_latch_hi  = 1'b1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_report    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // High-time holding register: captured at the fall that ends HIGH and
    // held until the following rise publishes the full period.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi_tmp <= '0;
        end else if (clear) begin
            r_hi_tmp <= '0;
        end else if (w_latch_hi) begin
            r_hi_tmp <= r_cnt;
        end
    end

    // ------------------------------------------------------------------------
    // Report registers. Values persist between reports; only valid pulses.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high_count   <= '0;
            low_count    <= '0;
            period_count <= '0;
            sat          <= 1'b0;
            valid        <= 1'b0;
        end else begin
            valid <= w_report;
            if (w_report) begin
                high_count   <= r_hi_tmp;
                low_count    <= r_cnt;
                period_count <= {1'b0, r_hi_tmp} + {1'b0, r_cnt};
                sat          <= (r_hi_tmp == c_max) | (r_cnt == c_max);
            end
        end
    end

endmodule : wave_duty_meter
`default_nettype wire

// File: tb/tb_wave_duty_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_duty_meter
//  Description : Self-checking bench for wave_duty_meter. Two instances
//                (CW=8 and CW=4) see the same waveform. A level-based model
//                predicts every report; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_duty_meter;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       clear;
    logic       sig_in;

    logic [7:0] hi8, lo8;
    logic [8:0] per8;
    logic       sat8, val8;
    logic [3:0] hi4, lo4;
    logic [4:0] per4;
    logic       sat4, val4;

    wave_duty_meter #(.CW(8), .SYNC(SYNC)) dut8 (
        .clock        (clk),
        .reset        (reset),
        .clear        (clear),
        .sig_in       (sig_in),
        .high_count   (hi8),
        .low_count    (lo8),
        .period_count (per8),
        .sat          (sat8),
        .valid        (val8)
    );

    wave_duty_meter #(.CW(4), .SYNC(SYNC)) dut4 (
        .clock        (clk),
        .reset        (reset),
        .clear        (clear),
        .sig_in       (sig_in),
        .high_count   (hi4),
        .low_count    (lo4),
        .period_count (per4),
        .sat          (sat4),
        .valid        (val4)
    );

    // ------------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------------
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int hi8, lo8, per8, sat8;
        int hi4, lo4, per4, sat4;
        int gap;    // cycles since previous report, -1 when not checked
    } rep_t;

    rep_t exp_q[$];

    function automatic int clip(input int v, input int cw);
        int m;
        m = (1 << cw) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic rep_t make_rep(input int h, input int l, input int gap);
        rep_t r;
        r.hi8  = clip(h, 8);
        r.lo8  = clip(l, 8);
        r.per8 = r.hi8 + r.lo8;
        r.sat8 = (h >= 255 || l >= 255) ? 1 : 0;
        r.hi4  = clip(h, 4);
        r.lo4  = clip(l, 4);
        r.per4 = r.hi4 + r.lo4;
        r.sat4 = (h >= 15 || l >= 15) ? 1 : 0;
        r.gap  = gap;
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Reference model, expressed in terms of whole levels of the waveform as
    // the meter sees it: a high counts only if a low was seen before it since
    // reset/clear, and a (high, low) pair is reported at the rise ending it.
    // ------------------------------------------------------------------------
    int cur_v, cur_len, hi_len;
    bit armed, have_hi, meas, first;

    task automatic model_edge(input int v);
        if (v != cur_v) begin
            if (v == 1) begin
                if (have_hi) begin
                    exp_q.push_back(make_rep(hi_len, cur_len, first ? -1 : hi_len + cur_len));
                    first = 0;
                end
                have_hi = 0;
                meas    = armed;
            end else begin
                if (meas) begin
                    hi_len  = cur_len;
                    have_hi = 1;
                end
                meas  = 0;
                armed = 1;
            end
            cur_v   = v;
            cur_len = 0;
        end
    endtask

    task automatic drive(input int v, input int n);
        model_edge(v);
        sig_in = v[0];
        repeat (n) @(negedge clk);
        cur_len += n;
    endtask

    // The synchronizer holds 0 through reset, so the meter always starts out
    // having seen a low level.
    task automatic do_reset(input logic lvl);
        reset  = 1'b1;
        clear  = 1'b0;
        sig_in = lvl;
        repeat (3) @(negedge clk);
        cur_v   = 0;
        cur_len = 0;
        hi_len  = 0;
        armed   = 1;
        have_hi = 0;
        meas    = 0;
        first   = 1;
        exp_q.delete();
        reset   = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: every cycle either a predicted report or unchanged outputs.
    // ------------------------------------------------------------------------
    int          cyc      = 0;
    int          last_cyc = 0;
    int          n_valids = 0;
    rep_t        mon_e;
    logic [25:0] held8 = '0;
    logic [13:0] held4 = '0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            held8 = '0;
            held4 = '0;
        end else begin
            chk("valid_pair", val8, val4);
            if (val8) begin
                n_valids++;
                chk("report_expected", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("high8",   hi8,  mon_e.hi8);
                    chk("low8",    lo8,  mon_e.lo8);
                    chk("period8", per8, mon_e.per8);
                    chk("sat8",    sat8, mon_e.sat8);
                    chk("high4",   hi4,  mon_e.hi4);
                    chk("low4",    lo4,  mon_e.lo4);
                    chk("period4", per4, mon_e.per4);
                    chk("sat4",    sat4, mon_e.sat4);
                    if (mon_e.gap >= 0) chk("report_gap", cyc - last_cyc, mon_e.gap);
                    held8 = {8'(mon_e.hi8), 8'(mon_e.lo8), 9'(mon_e.per8), 1'(mon_e.sat8)};
                    held4 = {4'(mon_e.hi4), 4'(mon_e.lo4), 5'(mon_e.per4), 1'(mon_e.sat4)};
                end
                last_cyc = cyc;
            end else begin
                chk("hold8", {hi8, lo8, per8, sat8}, held8);
                chk("hold4", {hi4, lo4, per4, sat4}, held4);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed vector table: {high, low, repeats} -> expected last report
    // ------------------------------------------------------------------------
    typedef struct {
        int hi, lo, reps;
        int hi8, lo8, per8, sat8;
        int hi4, lo4, per4, sat4;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int v0;
        int h, l;

        tbl[0] = '{3,   5,   3,   3,   5,   8,   0,  3,  5,  8,  0};
        tbl[1] = '{1,   1,   4,   1,   1,   2,   0,  1,  1,  2,  0};
        tbl[2] = '{20,  2,   2,   20,  2,   22,  0,  15, 2,  17, 1};
        tbl[3] = '{255, 1,   1,   255, 1,   256, 1,  15, 1,  16, 1};
        tbl[4] = '{300, 300, 1,   255, 255, 510, 1,  15, 15, 30, 1};
        tbl[5] = '{7,   16,  2,   7,   16,  23,  0,  7,  15, 22, 1};

        // Reset state, then a quiet low input.
        do_reset(1'b0);
        chk("reset_out8", {hi8, lo8, per8, sat8, val8}, 0);
        chk("reset_out4", {hi4, lo4, per4, sat4, val4}, 0);
        drive(0, 10);
        chk("idle_no_valid", n_valids, 0);

        // Directed periods, each followed by a short marker period whose
        // rise publishes the entry's last period.
        for (int i = 0; i < 6; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                drive(1, tbl[i].hi);
                drive(0, tbl[i].lo);
            end
            drive(1, 2);
            drive(0, 3);
            chk("tbl_high8",   hi8,  tbl[i].hi8);
            chk("tbl_low8",    lo8,  tbl[i].lo8);
            chk("tbl_period8", per8, tbl[i].per8);
            chk("tbl_sat8",    sat8, tbl[i].sat8);
            chk("tbl_high4",   hi4,  tbl[i].hi4);
            chk("tbl_low4",    lo4,  tbl[i].lo4);
            chk("tbl_period4", per4, tbl[i].per4);
            chk("tbl_sat4",    sat4, tbl[i].sat4);
        end

        // Latency from the first high sample of sig_in to valid.
        drive(1, 3);
        drive(0, 5);
        model_edge(1);
        sig_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (val8 && lat == 0) lat = k;
        end
        @(negedge clk);
        cur_len += 6;
        chk("latency", lat, SYNC + 1);
        drive(0, 4);

        // clear coinciding with the rise that ends LOW suppresses the report.
        drive(1, 3);
        drive(0, 5);
        sig_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        cur_v   = 1;
        cur_len = 3;
        armed   = 0;
        have_hi = 0;
        meas    = 0;
        first   = 1;
        chk("clear_no_valid", val8, 0);
        chk("clear_keeps_high", hi8, 6);
        chk("clear_keeps_low",  lo8, 4);
        drive(1, 2);
        drive(0, 5);
        drive(1, 3);
        drive(0, 5);
        v0 = n_valids;
        drive(1, 3);
        drive(0, 4);
        chk("after_clear_reports", n_valids - v0, 1);
        chk("after_clear_high", hi8, 3);
        chk("after_clear_low",  lo8, 5);

        // Input high across reset release.
        do_reset(1'b1);
        v0 = n_valids;
        drive(1, 6);
        drive(0, 4);
        chk("high_at_reset_no_early", n_valids - v0, 0);
        drive(1, 3);
        drive(0, 3);
        chk("high_at_reset_reports", n_valids - v0, 1);
        chk("high_at_reset_high", hi8, 6);
        chk("high_at_reset_low",  lo8, 4);

        // Randomized periods against the model.
        for (int i = 0; i < 40; i++) begin
            h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 280)) : int'($urandom_range(1, 12));
            l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 280)) : int'($urandom_range(1, 12));
            drive(1, h);
            drive(0, l);
        end
        drive(1, 2);
        drive(0, 12);
        chk("all_reports_seen", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_wave_duty_meter
`default_nettype wire
